// File: rtl/adc_threshold_capture_pkg.sv
// adc_capture_pkg: shared state type, lane constants and the saturating
// absolute-value helper for the ADC threshold capture stage.
package adc_capture_pkg;
  localparam int NUM_LANES   = 8;
  localparam int SAMPLE_BITS = 16;
  typedef enum logic [1:0] {IDLE, FILL, ARMED, CAPTURE} cap_state_t;
  // |s| with the most negative code clamped to the largest positive magnitude
  function automatic logic [SAMPLE_BITS-2:0] lane_abs(input logic signed [SAMPLE_BITS-1:0] s);
    logic [SAMPLE_BITS-1:0] m;
    m = s[SAMPLE_BITS-1] ? SAMPLE_BITS'(-s) : SAMPLE_BITS'(s);
    return m[SAMPLE_BITS-1] ? '1 : m[SAMPLE_BITS-2:0];
  endfunction
endpackage

// File: rtl/adc_threshold_capture_if.sv
// adc_threshold_capture_if: AXI4-Stream data/valid/ready bundle used on both
// the ADC side and the readout-buffer side of the capture stage.
interface adc_threshold_capture_if
  import adc_capture_pkg::*;
#(
  parameter int W = NUM_LANES * SAMPLE_BITS
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_threshold_capture_trig_detect.sv
// trig_detect: eight-lane saturating |sample| > threshold compare, OR-reduced,
// qualified by an enable, with both a same-cycle fire and a registered pulse.
module trig_detect
  import adc_capture_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en_i,
  input  logic                             force_i,
  input  logic [NUM_LANES*SAMPLE_BITS-1:0] data_i,
  input  logic [SAMPLE_BITS-2:0]           threshold_i,
  output logic                             fire_o,
  output logic                             fire_q_o
);
  logic [NUM_LANES-1:0] over;
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign over[i] = lane_abs(data_i[i*SAMPLE_BITS +: SAMPLE_BITS]) > threshold_i;
  end
  assign fire_o = en_i && ((|over) || force_i);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fire_q_o <= 1'b0;
    else        fire_q_o <= fire_o;
endmodule

// File: rtl/adc_threshold_capture.sv
// adc_threshold_capture: free-running delay line plus trigger FSM that emits a
// fixed window of pre- and post-trigger ADC beats to one readout buffer.
module adc_threshold_capture #(
  parameter int ADC_WIDTH     = 128,
  parameter int SAMPLE_BITS   = 16,
  parameter int PRETRIG_BEATS = 16,
  parameter int CAPTURE_BEATS = 256
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  adc_threshold_capture_if.slave  s_axis,
  adc_threshold_capture_if.master m_axis,
  input  logic [SAMPLE_BITS-2:0]  threshold,
  input  logic                    arm,
  input  logic                    force_trig,
  input  logic                    auto_rearm,
  output logic                    trig_out,
  output logic                    capture_done,
  output logic                    overflow,
  output logic                    busy
);
  import adc_capture_pkg::*;
  localparam int D  = PRETRIG_BEATS;
  localparam int L  = CAPTURE_BEATS;
  localparam int FW = $clog2(D + 1);
  localparam int WW = $clog2(L + 1);
  cap_state_t           state_q;
  logic [FW-1:0]        fill_q;
  logic [WW-1:0]        win_q;
  logic [ADC_WIDTH-1:0] dl_q [D];
  logic [ADC_WIDTH-1:0] m_tdata_q;
  logic                 m_tvalid_q;
  logic                 done_q;
  logic                 ovf_q;
  logic                 rdy_q;
  logic                 fire;
  // dl_q[D-1] is always the beat D valid beats older than the incoming one
  always_ff @(posedge aclk)
    if (s_axis.tvalid) begin
      dl_q[0] <= s_axis.tdata;
      for (int j = 1; j < D; j++) dl_q[j] <= dl_q[j-1];
    end
  trig_detect u_trig (
    .clk         (aclk),
    .rst_n       (aresetn),
    .en_i        (s_axis.tvalid && state_q == ARMED),
    .force_i     (force_trig),
    .data_i      (s_axis.tdata),
    .threshold_i (threshold),
    .fire_o      (fire),
    .fire_q_o    (trig_out)
  );
  // After the last window beat CAPTURE lingers two cycles: one to raise
  // capture_done, one to leave, so busy drops the cycle after the pulse.
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      win_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      done_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      if (s_axis.tvalid) m_tdata_q <= dl_q[D-1];
      if (m_tvalid_q && !m_axis.tready) ovf_q <= 1'b1;
      case (state_q)
        IDLE:
          if (arm) begin
            state_q <= FILL;
            fill_q  <= '0;
            ovf_q   <= 1'b0;
          end
        FILL:
          if (s_axis.tvalid) begin
            fill_q <= fill_q + 1'b1;
            if (fill_q == FW'(D - 1)) state_q <= ARMED;
          end
        ARMED:
          if (fire) begin
            state_q    <= CAPTURE;
            win_q      <= WW'(1);
            m_tvalid_q <= 1'b1;
          end
        CAPTURE:
          if (done_q) begin
            state_q <= auto_rearm ? ARMED : IDLE;
            win_q   <= '0;
          end else if (win_q == WW'(L)) begin
            done_q <= 1'b1;
          end else if (s_axis.tvalid) begin
            win_q      <= win_q + 1'b1;
            m_tvalid_q <= 1'b1;
          end
      endcase
    end
  assign s_axis.tready = rdy_q;
  assign m_axis.tdata  = m_tdata_q;
  assign m_axis.tvalid = m_tvalid_q;
  assign capture_done  = done_q;
  assign overflow      = ovf_q;
  assign busy          = state_q != IDLE;
endmodule

// File: tb/tb_adc_threshold_capture.sv
// tb_adc_threshold_capture: directed ramp stimulus against a beat-history
// window model, checked every cycle, plus hand-computed window expectations.
module tb_adc_threshold_capture;
  localparam int D = 4;
  localparam int L = 8;
  logic        clk;
  logic        rst_n;
  logic [14:0] threshold;
  logic        arm;
  logic        force_trig;
  logic        auto_rearm;
  logic        trig_out;
  logic        capture_done;
  logic        overflow;
  logic        busy;
  adc_threshold_capture_if #(.W(128)) s_if ();
  adc_threshold_capture_if #(.W(128)) m_if ();
  adc_threshold_capture #(
    .ADC_WIDTH     (128),
    .SAMPLE_BITS   (16),
    .PRETRIG_BEATS (D),
    .CAPTURE_BEATS (L)
  ) dut (
    .aclk         (clk),
    .aresetn      (rst_n),
    .s_axis       (s_if),
    .m_axis       (m_if),
    .threshold    (threshold),
    .arm          (arm),
    .force_trig   (force_trig),
    .auto_rearm   (auto_rearm),
    .trig_out     (trig_out),
    .capture_done (capture_done),
    .overflow     (overflow),
    .busy         (busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int n = 0;
  int cy = 0;
  int ntrig = 0;
  int ndone = 0;
  int hb;
  logic [127:0] got [$];
  int gcy [$];
  bit ovr = 1'b0;
  logic [15:0] l3v = '0;
  // model: mode 0 idle, 1 filling, 2 waiting for trigger, 3 window open
  int mode = 0;
  int fcnt = 0;
  int wcnt = 0;
  int tail = 0;
  bit e_v = 0, e_t = 0, e_d = 0, e_o = 0, e_r = 0;
  logic [127:0] e_data = '0;
  logic [127:0] hist [0:2047];
  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  function automatic bit is_hit(logic [127:0] d, int thr);
    for (int i = 0; i < 8; i++) begin
      int v;
      v = $signed(d[16*i +: 16]);
      if (v < 0) v = -v;
      if (v > 32767) v = 32767;
      if (v > thr) return 1'b1;
    end
    return 1'b0;
  endfunction
  function automatic logic [127:0] mk(int k);
    logic [127:0] d;
    d = {8{16'(k)}};
    if (ovr) d[63:48] = l3v;
    return d;
  endfunction
  task automatic model();
    bit pv;
    if (!rst_n) begin
      mode = 0; fcnt = 0; wcnt = 0; tail = 0;
      e_v = 0; e_t = 0; e_d = 0; e_o = 0; e_r = 0; e_data = '0;
      return;
    end
    pv = e_v;
    e_r = 1; e_v = 0; e_t = 0; e_d = 0;
    if (pv && !m_if.tready) e_o = 1;
    case (mode)
      0: if (arm) begin mode = 1; fcnt = 0; e_o = 0; end
      1: if (s_if.tvalid) begin fcnt++; if (fcnt == D) mode = 2; end
      2: if (s_if.tvalid && (is_hit(s_if.tdata, int'(threshold)) || force_trig)) begin
           mode = 3; wcnt = 1; tail = 0; e_t = 1; e_v = 1; e_data = hist[n-D];
         end
      3: if (wcnt == L) begin
           tail++;
           if (tail == 1) e_d = 1;
           else mode = auto_rearm ? 2 : 0;
         end else if (s_if.tvalid) begin
           wcnt++; e_v = 1; e_data = hist[n-D];
         end
      default: mode = 0;
    endcase
    if (s_if.tvalid) begin hist[n] = s_if.tdata; n++; end
  endtask
  task automatic compare();
    chk("tvalid", m_if.tvalid, e_v);
    if (e_v) chk("tdata", m_if.tdata, e_data);
    chk("trig_out", trig_out, e_t);
    chk("capture_done", capture_done, e_d);
    chk("overflow", overflow, e_o);
    chk("busy", busy, mode != 0);
    chk("s_tready", s_if.tready, e_r);
    if (m_if.tvalid) begin got.push_back(m_if.tdata); gcy.push_back(cy); end
    ntrig += int'(trig_out);
    ndone += int'(capture_done);
  endtask
  task automatic cyc(input bit v);
    s_if.tvalid = v;
    s_if.tdata  = v ? mk(n) : '0;
    @(posedge clk);
    model();
    @(negedge clk);
    cy++;
    compare();
    arm = 1'b0;
    force_trig = 1'b0;
  endtask
  task automatic clr();
    got.delete(); gcy.delete(); ntrig = 0; ndone = 0;
  endtask
  initial begin
    rst_n = 1'b0; s_if.tvalid = 1'b0; s_if.tdata = '0; m_if.tready = 1'b1;
    threshold = 15'd100; arm = 1'b0; force_trig = 1'b0; auto_rearm = 1'b0;
    repeat (3) cyc(0);
    chk("rst_tvalid", m_if.tvalid, 0);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    cyc(0);
    chk("tready_after_rst", s_if.tready, 1);
    // hit at beat 20: window 16..23
    clr(); arm = 1'b1; cyc(0);
    chk("t1_busy_rise", busy, 1);
    repeat (20) cyc(1);
    ovr = 1'b1; l3v = 16'hff38; cyc(1); ovr = 1'b0;
    chk("t1_trig", trig_out, 1);
    chk("t1_first_valid", m_if.tvalid, 1);
    repeat (12) cyc(1);
    chk("t1_count", got.size(), 8);
    chk("t1_first_beat", got[0], {8{16'd16}});
    chk("t1_last_beat", got[7], {8{16'd23}});
    chk("t1_hit_lane3", got[4][63:48], 16'hff38);
    chk("t1_ndone", ndone, 1);
    chk("t1_busy_fall", busy, 0);
    // hit during FILL is ignored
    threshold = 15'd1000; l3v = 16'hf830;
    clr(); arm = 1'b1; cyc(0);
    ovr = 1'b1; cyc(1); ovr = 1'b0;
    repeat (5) cyc(1);
    chk("t2_fill_hit_ignored", ntrig, 0);
    hb = n; ovr = 1'b1; cyc(1); ovr = 1'b0;
    chk("t2_trig", ntrig, 1);
    repeat (12) cyc(1);
    chk("t2_first_beat", got[0][15:0], 16'(hb - 4));
    chk("t2_count", got.size(), 8);
    // force_trig ignored in IDLE, -32768 is no hit at 32767, force in ARMED
    threshold = 15'h7fff;
    clr(); force_trig = 1'b1; cyc(1);
    chk("t3_force_idle", ntrig, 0);
    arm = 1'b1; cyc(0);
    repeat (4) cyc(1);
    ovr = 1'b1; l3v = 16'h8000; repeat (3) cyc(1);
    chk("t3_min_no_hit", ntrig, 0);
    hb = n; force_trig = 1'b1; cyc(1); ovr = 1'b0;
    chk("t3_force_trig", trig_out, 1);
    repeat (12) cyc(1);
    chk("t3_count", got.size(), 8);
    chk("t3_first_beat", got[0][15:0], 16'(hb - 4));
    chk("t3_last_beat", got[7][15:0], 16'(hb + 3));
    // 3-cycle input gap mid-window
    threshold = 15'd1000; l3v = 16'hf830;
    clr(); arm = 1'b1; cyc(0);
    repeat (4) cyc(1);
    hb = n; ovr = 1'b1; cyc(1); ovr = 1'b0;
    arm = 1'b1; repeat (3) cyc(1);
    repeat (3) cyc(0);
    repeat (10) cyc(1);
    chk("t4_count", got.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t4_beat%0d", i), got[i][15:0], 16'(hb - 4 + i));
    chk("t4_pre_gap", gcy[3] - gcy[0], 3);
    chk("t4_gap", gcy[4] - gcy[3], 4);
    chk("t4_post_gap", gcy[7] - gcy[4], 3);
    // buffer not ready for two presented beats
    clr(); arm = 1'b1; cyc(0);
    repeat (4) cyc(1);
    ovr = 1'b1; cyc(1); ovr = 1'b0;
    cyc(1);
    m_if.tready = 1'b0; repeat (2) cyc(1); m_if.tready = 1'b1;
    repeat (12) cyc(1);
    chk("t5_overflow", overflow, 1);
    chk("t5_count", got.size(), 8);
    chk("t5_ndone", ndone, 1);
    clr(); arm = 1'b1; cyc(0);
    chk("t5_arm_clears", overflow, 0);
    // auto re-arm with a hit on every beat, then reset mid-window
    auto_rearm = 1'b1;
    repeat (4) cyc(1);
    hb = n; ovr = 1'b1; repeat (24) cyc(1);
    chk("t6_ntrig", ntrig, 3);
    chk("t6_ndone", ndone, 2);
    chk("t6_count", got.size(), 20);
    chk("t6_win1", got[0][15:0], 16'(hb - 4));
    chk("t6_win2", got[8][15:0], 16'(hb + 6));
    chk("t6_win3", got[16][15:0], 16'(hb + 16));
    chk("t6_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_if.tvalid, 0);
    chk("t6_rst_tdata", m_if.tdata, 0);
    chk("t6_rst_trig", trig_out, 0);
    chk("t6_rst_done", capture_done, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_tready", s_if.tready, 0);
    repeat (2) cyc(1);
    rst_n = 1'b1; auto_rearm = 1'b0; ovr = 1'b0;
    repeat (3) cyc(1);
    chk("t6_idle_after_rst", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
